// File: rtl/im_pack_fifo_pkg.sv
// Shared defaults and helpers for the imager pixel packer / output buffer.
package im_pkg;

  localparam int IM_IN_W  = 6;
  localparam int IM_PACK  = 4;
  localparam int IM_DEPTH = 1024;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/im_pack_fifo_if.sv
// Sample-in / word-out bus of the pixel packer; master is the host/ADC side.
interface im_pack_fifo_if import im_pkg::*; #(
  parameter int IN_W  = IM_IN_W,
  parameter int PACK  = IM_PACK,
  parameter int DEPTH = IM_DEPTH
) ();

  localparam int OUT_W = IN_W * PACK;
  localparam int AW    = clog2(DEPTH);

  logic              test_en;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              flush;
  logic              out_rd;
  logic [AW:0]       thresh;
  logic [OUT_W-1:0]  out_data;
  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              thresh_flag;
  logic              overflow;
  logic              underflow;

  modport master (
    output test_en, in_data, in_valid, flush, out_rd, thresh,
    input  out_data, level, full, empty, thresh_flag, overflow, underflow
  );

  modport slave (
    input  test_en, in_data, in_valid, flush, out_rd, thresh,
    output out_data, level, full, empty, thresh_flag, overflow, underflow
  );

endinterface

// File: rtl/im_pack_fifo_sync_fifo.sv
// Single-clock word FIFO with occupancy count and registered read data.
module im_sync_fifo import im_pkg::*; #(
  parameter int W     = IM_IN_W * IM_PACK,
  parameter int DEPTH = IM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [clog2(DEPTH):0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [W-1:0]  rd_data_reg;
  logic          push;
  logic          pop;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign pop   = rd_en && !empty;
  // A write into a full buffer is still accepted when a read frees a slot this cycle.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = level_reg;

endmodule

// File: rtl/im_pack_fifo.sv
// Packs PACK ADC samples (or ramp test data) per word and buffers them for the host pipe.
module im_pack_fifo import im_pkg::*; #(
  parameter int IN_W  = IM_IN_W,
  parameter int PACK  = IM_PACK,
  parameter int DEPTH = IM_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  im_pack_fifo_if.slave bus
);

  localparam int OUT_W = IN_W * PACK;
  localparam int AW    = clog2(DEPTH);
  localparam int CW    = (PACK > 1) ? clog2(PACK) : 1;

  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [OUT_W-1:0] shift_reg;
  logic [OUT_W-1:0] shift_next;
  logic [IN_W-1:0]  tp_reg;
  logic             mode_reg;
  logic             wr_req_reg;
  logic [OUT_W-1:0] wr_word_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             mode_eff;
  logic [IN_W-1:0]  sample;
  logic             stage;
  logic             pop_ok;

  // The source mode is sampled live on the first lane and held for the rest of the word.
  assign mode_eff = (cnt_reg == '0) ? bus.test_en : mode_reg;
  assign sample   = mode_eff ? tp_reg : bus.in_data;
  assign pop_ok   = bus.out_rd && !bus.empty;

  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    stage      = 1'b0;
    if (bus.in_valid) begin
      shift_next = shift_reg | (OUT_W'(sample) << (int'(cnt_reg) * IN_W));
    end
    if ((bus.in_valid && (int'(cnt_reg) == PACK - 1)) ||
        (bus.flush && (bus.in_valid || (cnt_reg != '0)))) begin
      stage    = 1'b1;
      cnt_next = '0;
    end else if (bus.in_valid) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      shift_reg     <= '0;
      tp_reg        <= '0;
      mode_reg      <= 1'b0;
      wr_req_reg    <= 1'b0;
      wr_word_reg   <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg       <= '0;
      shift_reg     <= '0;
      tp_reg        <= '0;
      mode_reg      <= 1'b0;
      wr_req_reg    <= 1'b0;
      wr_word_reg   <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      // Clearing the register on staging keeps unfilled lanes of the next word zero.
      shift_reg  <= stage ? '0 : shift_next;
      wr_req_reg <= stage;
      if (stage) begin
        wr_word_reg <= shift_next;
      end
      if (cnt_reg == '0) begin
        mode_reg <= bus.test_en;
      end
      if (bus.in_valid) begin
        tp_reg <= tp_reg + 1'b1;
      end
      if (wr_req_reg && bus.full && !pop_ok) begin
        overflow_reg <= 1'b1;
      end
      if (bus.out_rd && bus.empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  im_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_req_reg),
    .wr_data (wr_word_reg),
    .rd_en   (bus.out_rd),
    .rd_data (bus.out_data),
    .level   (bus.level),
    .full    (bus.full),
    .empty   (bus.empty)
  );

  assign bus.thresh_flag = (bus.thresh != '0) && (bus.level >= bus.thresh);
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;

endmodule
